// File: rtl/filtb_pkg.sv
// Shared ADPCM constants for the long-term speed-control filters.
package filtb_pkg;

  localparam int FI_W           = 3;
  localparam int DM_W           = 14;
  localparam int FILTB_SHIFT    = 7;
  localparam int FILTB_FI_SHIFT = 11;
  localparam int FILTB_BIAS     = 32768;
  localparam int FILTB_SXT      = 16128;

endpackage

// File: rtl/lt_filter.sv
// Generic G.726 long-term average filter: dmlp = dml + ((fi << IN_SHIFT) - dml) >>> SHIFT,
// built with the bias/sign-extend arithmetic used by FILTA and FILTB.
module lt_filter #(
  parameter int IN_W     = 3,
  parameter int DM_W     = 14,
  parameter int IN_SHIFT = 11,
  parameter int SHIFT    = 7,
  parameter int BIAS     = 32768,
  parameter int SXT      = 16128
) (
  input  logic [IN_W-1:0] fi,
  input  logic [DM_W-1:0] dml,
  output logic [DM_W-1:0] dmlp
);

  localparam int DIF_W = DM_W + 1;

  logic signed [DIF_W-1:0] dif;
  logic        [DM_W-1:0]  difsx;

  // Shift the difference down and, when negative, fill the vacated top bits
  // by adding the sign-extension constant (floor rounding, no saturation).
  function automatic logic [DM_W-1:0] shift_sext(input logic signed [DIF_W-1:0] d);
    logic [DIF_W-1:0] mag;
    mag = unsigned'(d) >> SHIFT;
    return DM_W'(mag) + (d[DIF_W-1] ? DM_W'(SXT) : {DM_W{1'b0}});
  endfunction

  // Difference is taken modulo 2^DIF_W; the bias keeps the standard's form.
  always_comb begin
    dif   = signed'((DIF_W'(fi) << IN_SHIFT) + DIF_W'(BIAS) - DIF_W'(dml));
    difsx = shift_sext(dif);
    dmlp  = dml + difsx;
  end

endmodule

// File: rtl/filtb.sv
// FILTB: long-term average of the transformed quantizer output with a
// registered copy of the result for the surrounding codec.
module filtb #(
  parameter int FI_W  = filtb_pkg::FI_W,
  parameter int DM_W  = filtb_pkg::DM_W,
  parameter int SHIFT = filtb_pkg::FILTB_SHIFT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [FI_W-1:0] FI,
  input  logic [DM_W-1:0] DML,
  output logic [DM_W-1:0] DMLP,
  output logic [DM_W-1:0] DMLP_Q
);

  import filtb_pkg::FILTB_FI_SHIFT;
  import filtb_pkg::FILTB_BIAS;
  import filtb_pkg::FILTB_SXT;

  lt_filter #(
    .IN_W     (FI_W),
    .DM_W     (DM_W),
    .IN_SHIFT (FILTB_FI_SHIFT),
    .SHIFT    (SHIFT),
    .BIAS     (FILTB_BIAS),
    .SXT      (FILTB_SXT)
  ) u_filter (
    .fi   (FI),
    .dml  (DML),
    .dmlp (DMLP)
  );

  // Registered copy of the update; reset clears only this register.
  always_ff @(posedge clk) begin
    if (reset) DMLP_Q <= '0;
    else       DMLP_Q <= DMLP;
  end

endmodule

// File: tb/tb_filtb.sv
// Self-checking bench for filtb: directed table, reset sequence, exhaustive
// sweep and randomized registered/closed-loop runs against an arithmetic model.
module tb_filtb;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  FI;
  logic [13:0] DML;
  logic [13:0] DMLP;
  logic [13:0] DMLP_Q;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic [2:0]  fi;
    logic [13:0] dml;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  filtb dut (
    .clk    (clk),
    .reset  (reset),
    .FI     (FI),
    .DML    (DML),
    .DMLP   (DMLP),
    .DMLP_Q (DMLP_Q)
  );

  // Reference: DML + floor((FI*2048 - DML) / 128), modulo 2^14.
  function automatic logic [13:0] ref_dmlp(input int fi, input int dml);
    int diff;
    int step;
    diff = fi * 2048 - dml;
    step = diff >>> 7;
    return 14'((dml + step) & 16'h3FFF);
  endfunction

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h (FI=%0d DML=0x%04h)", name, act, exp, FI, DML);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] exp_q;
    logic [13:0] dml_m;
    logic [2:0]  fi_r;

    vecs[0] = '{"zero",        3'd0, 14'h0000, 14'h0000};
    vecs[1] = '{"fi7_dml0",    3'd7, 14'h0000, 14'h0070};
    vecs[2] = '{"neg_branch",  3'd0, 14'h3FFF, 14'h3F7F};
    vecs[3] = '{"steady7",     3'd7, 14'h3800, 14'h3800};
    vecs[4] = '{"fi2_dml100",  3'd2, 14'd100,  14'h0083};
    vecs[5] = '{"steady4",     3'd4, 14'h2000, 14'h2000};
    vecs[6] = '{"wrap_to_0",   3'd0, 14'h0001, 14'h0000};
    vecs[7] = '{"fi7_dmlmax",  3'd7, 14'h3FFF, 14'h3FEF};
    vecs[8] = '{"fi1_dml0",    3'd1, 14'h0000, 14'h0010};
    vecs[9] = '{"steady0",     3'd0, 14'h0000, 14'h0000};

    // Reset state
    reset = 1'b1; FI = 3'd0; DML = 14'h0000;
    repeat (2) @(posedge clk);
    #1 check("reset_q", DMLP_Q, 14'h0000);
    reset = 1'b0;
    @(posedge clk);
    #1 check("q_zero_after_clk", DMLP_Q, 14'h0000);

    // Directed table on the combinational path
    for (int i = 0; i < 10; i++) begin
      FI = vecs[i].fi; DML = vecs[i].dml;
      #1 check(vecs[i].name, DMLP, vecs[i].exp);
    end

    // Registered path and reset priority
    @(posedge clk); #1;
    FI = 3'd7; DML = 14'h0000;
    @(posedge clk);
    #1 check("q_fi7", DMLP_Q, 14'h0070);
    reset = 1'b1;
    @(posedge clk);
    #1 check("q_in_reset", DMLP_Q, 14'h0000);
    check("dmlp_in_reset", DMLP, 14'h0070);
    reset = 1'b0;
    @(posedge clk);
    #1 check("q_after_reset", DMLP_Q, 14'h0070);

    // Exhaustive combinational sweep
    for (int f = 0; f < 8; f++) begin
      for (int d = 0; d < 16384; d++) begin
        FI = 3'(f); DML = 14'(d);
        #1 check("sweep", DMLP, ref_dmlp(f, d));
      end
    end

    // Random open-loop stream with occasional reset, inputs driven after the edge
    @(posedge clk); #1;
    FI = 3'($urandom_range(0, 7)); DML = 14'($urandom);
    reset = 1'b0;
    exp_q = ref_dmlp(int'(FI), int'(DML));
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1 check("rand_q", DMLP_Q, exp_q);
      FI = 3'($urandom_range(0, 7));
      DML = 14'($urandom);
      reset = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      check("rand_dmlp", DMLP, ref_dmlp(int'(FI), int'(DML)));
      exp_q = reset ? 14'h0000 : ref_dmlp(int'(FI), int'(DML));
    end
    @(posedge clk);
    #1 check("rand_q_last", DMLP_Q, exp_q);
    reset = 1'b0;

    // Closed loop: DML fed back from DMLP_Q, model integrates independently
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    dml_m = 14'h0000;
    for (int c = 0; c < 300; c++) begin
      fi_r = (c < 150) ? 3'd5 : 3'($urandom_range(0, 7));
      FI = fi_r; DML = DMLP_Q;
      @(negedge clk);
      check("loop_dmlp", DMLP, ref_dmlp(int'(fi_r), int'(dml_m)));
      dml_m = ref_dmlp(int'(fi_r), int'(dml_m));
      @(posedge clk);
      #1 check("loop_q", DMLP_Q, dml_m);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/filtb.md
Name: filtb

Overview:
- G.726 ADPCM long-term speed-control filter (FILTB, adaptation-speed control block).
- Produces the next long-term average `DMLP` of the transformed quantizer output `FI`, from the previous average `DML`.
- The filter update is combinational, so a result applied in one half-cycle is valid by the next.
- A clocked registered copy is provided so the block can hold its own state for the surrounding encoder/decoder.

Parameters:
- FI_W, 3, width of FI (unsigned magnitude 0..7).
- DM_W, 14, width of DML/DMLP (unsigned fixed point).
- SHIFT, 7, filter time-constant shift (gain 2^-7).

Ports:
- clk  in  1  system clock; rising-edge active.
- reset  in  1  synchronous, active-high reset.
- FI  in  3  transformed quantizer output, range 0..7.
- DML  in  14  previous long-term average.
- DMLP  out  14  updated long-term average (combinational).
- DMLP_Q  out  14  registered copy of DMLP.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- DMLP is purely combinational from FI and DML:
  - No clock dependency.
  - Settles within the same half-cycle as an input change.
  - Never X when inputs are known.
- Arithmetic, exactly bit-compatible with ITU G.726 FILTB:
  - DIF = ((FI << 11) + 32768 − DML) mod 2^15, a 15-bit two's-complement difference.
  - DIFS = DIF[14], the sign bit.
  - DIFSX = DIF >> 7, 8 bits. If DIFS = 1, add 16128 (0x3F00), which sign-extends to 14 bits.
  - DMLP = (DIFSX + DML) mod 2^14. The carry is discarded and there is no saturation.
- Equivalent form: DMLP = DML + arithmetic_shift_right((FI·2048) − DML, 7), truncated to 14 bits.
  - Rounding is toward −∞ (arithmetic shift).
- Steady state: DML = FI·2048 gives DMLP = DML.
- FI above 7 cannot occur (3-bit port). All 8×16384 input combinations are legal.
- DMLP_Q:
  - On each rising clk, DMLP_Q <= DMLP.
  - When reset = 1 at a rising edge, DMLP_Q <= 0; reset has priority.
  - Reset has no effect on the combinational DMLP.
  - Reset value of DMLP_Q is 0x0000.
  - Latency: 1 clock from a DML/FI change to DMLP_Q.
- No handshake, no enable, no state machine.
- Reset asserted mid-stream clears DMLP_Q only.
- The external DML feedback (DML <= DMLP_Q) is the integrator's responsibility.

Decomposition:
- Shared ADPCM package holds:
  - Widths FI_W = 3, DM_W = 14.
  - Constants FILTB_SHIFT = 7, FILTB_FI_SHIFT = 11, FILTB_BIAS = 32768, FILTB_SXT = 16128.
- FILTA (DMS filter, shift 5, 12-bit) uses the same structure. A common sub-module `lt_filter` (parameterised width/shift) is natural; filtb instantiates it plus the output register.

Test Plan:
- FI = 0, DML = 0x0000 -> DMLP = 0x0000. After a clock with reset = 0, DMLP_Q = 0x0000.
- FI = 7, DML = 0x0000 -> DMLP = 0x0070 (112).
- FI = 0, DML = 0x3FFF -> DMLP = 0x3F7F (16255). This checks the negative branch with sign extension.
- FI = 7, DML = 0x3800 (14336) -> DMLP = 0x3800 (steady state). FI = 2, DML = 100 -> DMLP = 131 (0x0083).
- Registered path and reset:
  - Apply FI = 7, DML = 0 and clock -> DMLP_Q = 0x0070.
  - Assert reset for one edge with the same inputs -> DMLP_Q = 0x0000 while DMLP still = 0x0070.
  - Deassert -> next edge DMLP_Q = 0x0070.
- Vector regression: golden G.726 A-law and µ-law homing vectors at 16/24/32/40 kbit/s, 19880 samples each.
  - Drive FI/DML at the rising edge.
  - Compare DMLP at the falling edge; zero mismatches required.
- Supplementary: exhaustive sweep of all FI × DML combinations against a reference model.
